// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between instruction fetch and
//                the data (load/store) stage. It grants one access at a time,
//                drives the fetch/memory stall requests, forces a fetch after
//                a run of data grants, and aborts accesses to a hung memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int XLEN        = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst,

    // Fetch stage
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,

    // Memory stage
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [2:0]      dm_strCtrl,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_valid,

    // Memory port
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_size,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,

    // Hazard / status
    output logic            stallF,
    output logic            stallM,
    output logic            timeout_err
);

    // Size code used for every instruction fetch (full word)
    localparam logic [2:0] c_SIZE_WORD = 3'b010;

    // Starvation counter must be able to hold STARVE_MAX itself
    localparam int c_STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [c_STARVE_W-1:0] c_STARVE_TOP = c_STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arbState_t;

    arbState_t              r_state;
    arbState_t              w_nextState;

    logic                   w_grantI;
    logic                   w_grantD;
    logic                   w_memReq;
    logic                   w_busy;
    logic                   w_abort;
    logic                   w_done;
    logic                   w_forceFetch;

    logic [c_STARVE_W-1:0]  r_starveCnt;

    logic                   r_memWe;
    logic [XLEN-1:0]        r_memAddr;
    logic [XLEN-1:0]        r_memWdata;
    logic [2:0]             r_memSize;

    logic [XLEN-1:0]        r_ifRdata;
    logic [XLEN-1:0]        r_dmRdata;
    logic                   r_ifValid;
    logic                   r_dmValid;
    logic                   r_timeoutErr;

    // A pending fetch that has already lost STARVE_MAX data grants in a row
    // overrides the normal data-first priority.
    assign w_forceFetch = if_req && (r_starveCnt == c_STARVE_TOP);

    assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);

    // The access finishes on a memory handshake or on a timeout abort; the
    // abort term is only ever true while mem_ready is low.
    assign w_done = w_busy && (mem_ready || w_abort);

    // State register; async reset drops any in-flight access immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state, grant decisions and the memory request strobe
    always_comb begin
        w_nextState = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        w_memReq    = 1'b0;
        case (r_state)
            IDLE: begin
                // Data wins ties: the memory stage holds the older instruction
                if (dm_req && !w_forceFetch) begin
                    w_grantD    = 1'b1;
                    w_nextState = BUSY_D;
                end else if (if_req) begin
                    w_grantI    = 1'b1;
                    w_nextState = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                w_memReq = 1'b1;
                if (w_done) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                // Requester updates its request during this cycle, so no regrant
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Timeout watchdog, removed entirely when TIMEOUT_CYC is zero
    generate
        if (TIMEOUT_CYC > 0) begin : g_timeoutOn
            localparam int c_BUSY_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
            localparam logic [c_BUSY_W-1:0] c_BUSY_LAST = c_BUSY_W'(TIMEOUT_CYC - 1);

            logic [c_BUSY_W-1:0] r_busyCnt;

            // Counts busy cycles spent waiting; never passes c_BUSY_LAST
            // because reaching it without mem_ready ends the access.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_busyCnt <= '0;
                end else if (w_grantI || w_grantD) begin
                    r_busyCnt <= '0;
                end else if (w_busy && !mem_ready && !w_abort) begin
                    r_busyCnt <= r_busyCnt + 1'b1;
                end
            end

            assign w_abort = w_busy && !mem_ready && (r_busyCnt == c_BUSY_LAST);
        end else begin : g_timeoutOff
            assign w_abort = 1'b0;
        end
    endgenerate

    // Starvation counter: data grants taken while a fetch was waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starveCnt <= '0;
        end else if (w_grantI) begin
            r_starveCnt <= '0;
        end else if (w_grantD && if_req && (r_starveCnt != c_STARVE_TOP)) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end

    // Memory command registers, loaded from the winner at grant time and
    // held stable for the whole busy phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memSize  <= c_SIZE_WORD;
        end else if (w_grantD) begin
            r_memWe    <= dm_we;
            r_memAddr  <= dm_addr;
            r_memWdata <= dm_wdata;
            r_memSize  <= dm_strCtrl;
        end else if (w_grantI) begin
            r_memWe    <= 1'b0;
            r_memAddr  <= if_addr;
            r_memWdata <= '0;
            r_memSize  <= c_SIZE_WORD;
        end else if (w_done) begin
            // Write strobe is not left asserted once the access has ended
            r_memWe    <= 1'b0;
        end
    end

    // Read data capture; an aborted access returns zero to its owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifRdata <= '0;
            r_dmRdata <= '0;
        end else if (w_done) begin
            if (r_state == BUSY_I) begin
                r_ifRdata <= w_abort ? '0 : mem_rdata;
            end else if (w_abort) begin
                r_dmRdata <= '0;
            end else if (!r_memWe) begin
                // Stores leave the previous load data in place
                r_dmRdata <= mem_rdata;
            end
        end
    end

    // One-cycle completion pulses, high exactly while in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifValid <= 1'b0;
            r_dmValid <= 1'b0;
        end else begin
            r_ifValid <= w_done && (r_state == BUSY_I);
            r_dmValid <= w_done && (r_state == BUSY_D);
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeoutErr <= 1'b0;
        end else if (w_abort) begin
            r_timeoutErr <= 1'b1;
        end
    end

    assign mem_req     = w_memReq;
    assign mem_we      = r_memWe;
    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;
    assign mem_size    = r_memSize;

    assign if_rdata    = r_ifRdata;
    assign if_valid    = r_ifValid;
    assign dm_rdata    = r_dmRdata;
    assign dm_valid    = r_dmValid;
    assign timeout_err = r_timeoutErr;

    assign stallF      = if_req & ~r_ifValid;
    assign stallM      = dm_req & ~r_dmValid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter. Expected responses and
//                expected memory accesses are queued at issue time; a monitor
//                pops and compares them whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_valid;
    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [2:0]      dm_strCtrl;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_valid;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [2:0]      mem_size;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic            stallF;
    logic            stallM;
    logic            timeout_err;

    mem_port_arbiter #(
        .XLEN       (XLEN),
        .STARVE_MAX (4),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_strCtrl (dm_strCtrl),
        .dm_rdata   (dm_rdata),
        .dm_valid   (dm_valid),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_size   (mem_size),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .stallF     (stallF),
        .stallM     (stallM),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [2:0]  size;
    } acc_t;

    logic [31:0] ifExpQ[$];
    logic [31:0] dmExpQ[$];
    acc_t        accQ[$];
    logic [31:0] memImg [logic [31:0]];

    int memWait;
    bit memHang;
    int total;
    int bad;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic failNote(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    function automatic acc_t mkAcc(input logic [31:0] a, input logic w,
                                   input logic [31:0] d, input logic [2:0] s);
        acc_t t;
        t.addr  = a;
        t.we    = w;
        t.wdata = d;
        t.size  = s;
        return t;
    endfunction

    // Memory model: answers after memWait wait cycles unless hung
    initial begin : responder
        int wc;
        wc        = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !rst) begin
                mem_ready = !memHang && (wc == memWait);
                mem_rdata = memImg.exists(mem_addr) ? memImg[mem_addr] : 32'hBAD0_0000;
                wc        = mem_ready ? 0 : wc + 1;
            end else begin
                mem_ready = 1'b0;
                wc        = 0;
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a response or access
    initial begin : monitor
        bit          prevReq;
        acc_t        cur;
        logic [31:0] e;
        prevReq = 1'b0;
        cur     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevReq = 1'b0;
            end else begin
                if (if_valid) begin
                    if (ifExpQ.size() == 0) failNote("if_valid with no pending fetch");
                    else begin
                        e = ifExpQ.pop_front();
                        check("if_rdata", if_rdata, e);
                    end
                end
                if (dm_valid) begin
                    if (dm_valid && dmExpQ.size() == 0) failNote("dm_valid with no pending data access");
                    else begin
                        e = dmExpQ.pop_front();
                        check("dm_rdata", dm_rdata, e);
                    end
                end
                if (mem_req && !prevReq) begin
                    if (accQ.size() == 0) failNote("mem_req with no expected access");
                    else cur = accQ.pop_front();
                end
                if (mem_req) begin
                    check("mem_access {addr,we,size,wdata}",
                          {mem_addr, mem_we, mem_size, (mem_we ? mem_wdata : 32'h0)},
                          {cur.addr, cur.we, cur.size, (cur.we ? cur.wdata : 32'h0)});
                end
                prevReq = mem_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a valid pulse; stallSel 1 checks stallF, 2 checks stallM while waiting
    task automatic waitValid(input bit isData, input int budget, input int stallSel,
                             input string nm, output int lat, output int reqCyc);
        bit got;
        got    = 1'b0;
        lat    = 0;
        reqCyc = 0;
        while (!got && lat < budget) begin
            @(negedge clk);
            if (mem_req) reqCyc++;
            if (isData ? dm_valid : if_valid) got = 1'b1;
            else begin
                lat++;
                if (stallSel == 1) check({nm, " stallF"}, stallF, 1'b1);
                else if (stallSel == 2) check({nm, " stallM"}, stallM, 1'b1);
            end
        end
        if (!got) failNote({nm, " valid never arrived"});
    endtask

    initial begin : stimulus
        int lat;
        int rc;
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        dm_wdata   = '0;
        dm_strCtrl = 3'b000;
        memWait    = 0;
        memHang    = 1'b0;

        memImg[32'h0000_0100] = 32'h0050_0093;
        memImg[32'h0000_0104] = 32'h00A0_0113;
        memImg[32'h0000_0108] = 32'h0010_8093;
        memImg[32'h0000_2000] = 32'h1234_5678;
        memImg[32'h0000_3000] = 32'hA000_0001;
        memImg[32'h0000_3004] = 32'hA000_0002;
        memImg[32'h0000_3008] = 32'hA000_0003;
        memImg[32'h0000_300C] = 32'hA000_0004;
        memImg[32'h0000_3010] = 32'hA000_0005;
        memImg[32'h0000_0060] = 32'hCAFE_F00D;
        memImg[32'h0000_0200] = 32'h0000_0013;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst mem_req", mem_req, 1'b0);
        check("rst valids/we/err", {if_valid, dm_valid, mem_we, timeout_err}, 4'b0000);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_size", mem_size, 3'b010);
        check("rst rdata", {if_rdata, dm_rdata}, 64'h0);
        check("rst stallF", stallF, 1'b0);
        #1 rst = 1'b0;

        // 1. Lone fetch, zero-wait memory
        tick();
        if_addr = 32'h100;
        if_req  = 1'b1;
        ifExpQ.push_back(32'h0050_0093);
        accQ.push_back(mkAcc(32'h100, 1'b0, 32'h0, 3'b010));
        waitValid(1'b0, 20, 1, "t1 fetch", lat, rc);
        check("t1 valid latency", lat, 2);
        check("t1 mem_req cycles", rc, 1);
        check("t1 stallF at valid", stallF, 1'b0);
        #1 if_req = 1'b0;

        // 2. Simultaneous fetch and load: data first, then fetch
        tick();
        if_addr    = 32'h104;
        if_req     = 1'b1;
        dm_addr    = 32'h2000;
        dm_we      = 1'b0;
        dm_strCtrl = 3'b100;
        dm_req     = 1'b1;
        dmExpQ.push_back(32'h1234_5678);
        ifExpQ.push_back(32'h00A0_0113);
        accQ.push_back(mkAcc(32'h2000, 1'b0, 32'h0, 3'b100));
        accQ.push_back(mkAcc(32'h104, 1'b0, 32'h0, 3'b010));
        waitValid(1'b1, 20, 1, "t2 data", lat, rc);
        check("t2 data latency", lat, 2);
        #1 dm_req = 1'b0;
        waitValid(1'b0, 20, 1, "t2 fetch", lat, rc);
        check("t2 fetch latency", lat, 2);
        #1 if_req = 1'b0;

        // 3. Starvation: four data grants, then a forced fetch
        tick();
        if_addr    = 32'h108;
        if_req     = 1'b1;
        dm_we      = 1'b0;
        dm_strCtrl = 3'b010;
        dm_addr    = 32'h3000;
        dm_req     = 1'b1;
        dmExpQ.push_back(32'hA000_0001);
        dmExpQ.push_back(32'hA000_0002);
        dmExpQ.push_back(32'hA000_0003);
        dmExpQ.push_back(32'hA000_0004);
        dmExpQ.push_back(32'hA000_0005);
        ifExpQ.push_back(32'h0010_8093);
        accQ.push_back(mkAcc(32'h3000, 1'b0, 32'h0, 3'b010));
        accQ.push_back(mkAcc(32'h3004, 1'b0, 32'h0, 3'b010));
        accQ.push_back(mkAcc(32'h3008, 1'b0, 32'h0, 3'b010));
        accQ.push_back(mkAcc(32'h300C, 1'b0, 32'h0, 3'b010));
        accQ.push_back(mkAcc(32'h108, 1'b0, 32'h0, 3'b010));
        accQ.push_back(mkAcc(32'h3010, 1'b0, 32'h0, 3'b010));
        for (int k = 0; k < 4; k++) begin
            waitValid(1'b1, 20, 1, "t3 data", lat, rc);
            check("t3 starve_cnt", dut.r_starveCnt, k + 1);
            #1 dm_addr = 32'h3000 + 32'(4 * (k + 1));
        end
        waitValid(1'b0, 20, 1, "t3 forced fetch", lat, rc);
        check("t3 starve_cnt after fetch", dut.r_starveCnt, 0);
        #1 if_req = 1'b0;
        waitValid(1'b1, 20, 2, "t3 last data", lat, rc);
        check("t3 starve_cnt no fetch pending", dut.r_starveCnt, 0);
        #1 dm_req = 1'b0;

        // 4. Store with three wait cycles; load data left untouched
        memWait = 3;
        tick();
        dm_we      = 1'b1;
        dm_addr    = 32'h40;
        dm_wdata   = 32'hDEAD_BEEF;
        dm_strCtrl = 3'b010;
        dm_req     = 1'b1;
        dmExpQ.push_back(32'hA000_0005);
        accQ.push_back(mkAcc(32'h40, 1'b1, 32'hDEAD_BEEF, 3'b010));
        waitValid(1'b1, 30, 2, "t4 store", lat, rc);
        check("t4 mem_req cycles", rc, 4);
        check("t4 valid latency", lat, 5);
        #1;
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        memWait = 0;

        // Boundary: mem_ready on the last allowed busy cycle completes normally
        memWait = 7;
        tick();
        dm_addr    = 32'h60;
        dm_strCtrl = 3'b010;
        dm_req     = 1'b1;
        dmExpQ.push_back(32'hCAFE_F00D);
        accQ.push_back(mkAcc(32'h60, 1'b0, 32'h0, 3'b010));
        waitValid(1'b1, 40, 2, "t4b late ready", lat, rc);
        check("t4b mem_req cycles", rc, 8);
        check("t4b timeout_err", timeout_err, 1'b0);
        #1;
        dm_req  = 1'b0;
        memWait = 0;

        // 5. Hung memory: abort after 8 busy cycles
        memHang = 1'b1;
        tick();
        dm_addr    = 32'h50;
        dm_strCtrl = 3'b000;
        dm_req     = 1'b1;
        dmExpQ.push_back(32'h0);
        accQ.push_back(mkAcc(32'h50, 1'b0, 32'h0, 3'b000));
        waitValid(1'b1, 40, 2, "t5 timeout", lat, rc);
        check("t5 mem_req cycles", rc, 8);
        check("t5 timeout_err", timeout_err, 1'b1);
        #1;
        dm_req  = 1'b0;
        memHang = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("t5 timeout_err sticky", timeout_err, 1'b1);

        // 6. Async reset in the middle of a data access
        memHang = 1'b1;
        tick();
        dm_addr    = 32'h70;
        dm_strCtrl = 3'b010;
        dm_req     = 1'b1;
        dmExpQ.push_back(32'hFFFF_FFFF);
        accQ.push_back(mkAcc(32'h70, 1'b0, 32'h0, 3'b010));
        @(negedge clk);
        @(negedge clk);
        check("t6 mem_req before rst", mem_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t6 async mem_req", mem_req, 1'b0);
        check("t6 async err/we/valid", {timeout_err, mem_we, dm_valid}, 3'b000);
        check("t6 async mem_addr", mem_addr, 32'h0);
        check("t6 async mem_size", mem_size, 3'b010);
        dmExpQ.delete();
        dm_req  = 1'b0;
        memHang = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        if_addr = 32'h200;
        if_req  = 1'b1;
        ifExpQ.push_back(32'h0000_0013);
        accQ.push_back(mkAcc(32'h200, 1'b0, 32'h0, 3'b010));
        waitValid(1'b0, 20, 1, "t6 fetch after rst", lat, rc);
        check("t6 fetch latency", lat, 2);
        check("t6 timeout_err", timeout_err, 1'b0);
        #1 if_req = 1'b0;

        repeat (2) tick();
        check("leftover fetch responses", ifExpQ.size(), 0);
        check("leftover data responses", dmExpQ.size(), 0);
        check("leftover memory accesses", accQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
